gpio_axis_rr_arbiter: RTL and testbench

Merges several GPIO-style write sources (a level `wen` plus `wdata`) into one AXI-Stream master. It sits between N AXI-GPIO write channels and a single downstream stream consumer, which is either the stream FIFO or a DMA. Each source has a one-entry holding register. A round-robin arbiter feeds a registered output stage. Writes that arrive while a source's holding register is still occupied are dropped and flagged.

---
 rtl/gpio_arb_pkg.sv | 28 ++
 rtl/gpio_arb_rr_pick.sv | 35 +++
 rtl/gpio_axis_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_gpio_axis_rr_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_arb_pkg.sv
// Shared definitions for the GPIO-to-AXI-Stream round-robin arbiter:
// width helpers and the output-stage state encoding.
package gpio_arb_pkg;

  // Ceiling log2 for elaboration-time width calculation.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width of a source index; never narrower than one bit.
  function automatic int src_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/gpio_arb_rr_pick.sv
// Combinational rotate-priority picker: grants the first requester found
// when searching upward from ptr, wrapping modulo NUM_SRC.
module gpio_arb_rr_pick
  import gpio_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [SRC_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  localparam logic [SRC_W:0] NUM_W = (SRC_W + 1)'(NUM_SRC);

  // Walk offsets from the far end down to zero so the nearest requester wins.
  always_comb begin
    logic [SRC_W:0] sum;
    gnt_any = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int off = NUM_SRC - 1; off >= 0; off--) begin
      sum = {1'b0, ptr} + (SRC_W + 1)'(off);
      if (sum >= NUM_W) begin
        sum = sum - NUM_W;
      end
      if (req[sum[SRC_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = sum[SRC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/gpio_axis_rr_arbiter.sv
// Merges NUM_SRC level-strobed GPIO write sources into one AXI-Stream master.
// Each source has a one-entry holding register; a round-robin picker feeds a
// registered output stage. Writes that hit an occupied hold are dropped and
// flagged in a sticky overflow bit.
// Optional: define GPIO_ARB_TUSER_EN to add m_axis_tuser (granted source index).
module gpio_axis_rr_arbiter
  import gpio_arb_pkg::*;
#(
  parameter  int NUM_SRC    = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int SRC_W      = src_w(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC-1:0]            src_wen,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_wdata,
  output logic [NUM_SRC-1:0]            overflow,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
`ifdef GPIO_ARB_TUSER_EN
  output logic [SRC_W-1:0]              m_axis_tuser,
`endif
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready
);

  logic [NUM_SRC-1:0]    wen_q;
  logic [NUM_SRC-1:0]    push;
  logic [NUM_SRC-1:0]    hold_v_q;
  logic [DATA_WIDTH-1:0] hold_d_q [NUM_SRC];
  logic [NUM_SRC-1:0]    overflow_q;
  out_state_e            state_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [SRC_W-1:0]      rr_ptr_q;
  logic [SRC_W-1:0]      rr_ptr_d;
  logic [SRC_W-1:0]      gnt_idx;
  logic                  gnt_any;
  logic                  out_v;
  logic                  load;

  assign push  = src_wen & ~wen_q;
  assign out_v = (state_q == OUT_FULL);
  assign load  = gnt_any & (~out_v | m_axis_tready);

  assign rr_ptr_d = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);

  gpio_arb_rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_pick (
    .req     (hold_v_q),
    .ptr     (rr_ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Remember last wen level so a held-high strobe enqueues only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q <= '0;
    end else begin
      wen_q <= src_wen;
    end
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic granted;
    assign granted = load && (gnt_idx == SRC_W'(gi));

    // Holding register: a drained slot (or one draining this cycle) takes the
    // new word; otherwise the word is dropped and the overflow flag latches.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_v_q[gi]   <= 1'b0;
        hold_d_q[gi]   <= '0;
        overflow_q[gi] <= 1'b0;
      end else if (push[gi] && (!hold_v_q[gi] || granted)) begin
        hold_v_q[gi] <= 1'b1;
        hold_d_q[gi] <= src_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        if (granted) begin
          hold_v_q[gi] <= 1'b0;
        end
        if (push[gi]) begin
          overflow_q[gi] <= 1'b1;
        end
      end
    end
  end

  // Output stage FSM: load from the grant whenever the register is free or
  // being consumed; the pointer advances only on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OUT_EMPTY;
      tdata_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        OUT_EMPTY: begin
          if (load) begin
            state_q  <= OUT_FULL;
            tdata_q  <= hold_d_q[gnt_idx];
            rr_ptr_q <= rr_ptr_d;
          end
        end
        OUT_FULL: begin
          if (load) begin
            tdata_q  <= hold_d_q[gnt_idx];
            rr_ptr_q <= rr_ptr_d;
          end else if (m_axis_tready) begin
            state_q <= OUT_EMPTY;
          end
        end
        default: state_q <= OUT_EMPTY;
      endcase
    end
  end

`ifdef GPIO_ARB_TUSER_EN
  logic [SRC_W-1:0] tuser_q;

  // Source index travels with the payload it describes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tuser_q <= '0;
    end else if (load) begin
      tuser_q <= gnt_idx;
    end
  end

  assign m_axis_tuser = tuser_q;
`endif

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = out_v;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_gpio_axis_rr_arbiter.sv
// Scoreboard bench for gpio_axis_rr_arbiter (NUM_SRC=4, DATA_WIDTH=32).
module tb_gpio_axis_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    src_wen;
  logic [N*DW-1:0] src_wdata;
  logic [N-1:0]    overflow;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
`ifdef GPIO_ARB_TUSER_EN
  logic [1:0]      m_axis_tuser;
`endif

  gpio_axis_rr_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_wen       (src_wen),
    .src_wdata     (src_wdata),
    .overflow      (overflow),
    .m_axis_tdata  (m_axis_tdata),
`ifdef GPIO_ARB_TUSER_EN
    .m_axis_tuser  (m_axis_tuser),
`endif
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- reference model (abstract per-source slots) -----------
  typedef struct {
    logic [31:0] d;
    int          s;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] seen_q[$];
  bit          m_hv[N];
  logic [31:0] m_hd[N];
  logic [N-1:0] m_ovf;
  bit          m_outv;
  logic [31:0] m_outd;
  int          m_ptr;
  logic [N-1:0] m_wprev;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_hv[i] = 1'b0;
      m_hd[i] = '0;
    end
    m_ovf   = '0;
    m_outv  = 1'b0;
    m_outd  = '0;
    m_ptr   = 0;
    m_wprev = '0;
    exp_q.delete();
  endfunction

  function automatic void model_step(logic [N-1:0] wen, logic [N*DW-1:0] wd, logic rdy);
    int g;
    bit ld;
    bit hv_old[N];
    beat_t b;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && m_hv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    for (int i = 0; i < N; i++) hv_old[i] = m_hv[i];
    ld = (g >= 0) && (!m_outv || rdy);
    if (ld) begin
      m_outv = 1'b1;
      m_outd = m_hd[g];
      b.d = m_hd[g];
      b.s = g;
      exp_q.push_back(b);
      m_hv[g] = 1'b0;
      m_ptr = (g + 1) % N;
    end else if (m_outv && rdy) begin
      m_outv = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (wen[i] && !m_wprev[i]) begin
        if (!hv_old[i] || (ld && g == i)) begin
          m_hv[i] = 1'b1;
          m_hd[i] = wd[i*DW +: DW];
        end else begin
          m_ovf[i] = 1'b1;
        end
      end
    end
    m_wprev = wen;
  endfunction

  // Drive one cycle of inputs, let the DUT and model advance on the same edge.
  task automatic step(input logic [N-1:0] wen, input logic [N*DW-1:0] wd, input logic rdy);
    src_wen       = wen;
    src_wdata     = wd;
    m_axis_tready = rdy;
    @(posedge clk);
    if (rst_n) model_step(wen, wd, rdy);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step('0, '0, rdy);
  endtask

  // ---------------- monitor ------------------------------------------------
  int   nbeats = 0;
  bit   fair_phase = 1'b0;
  int   fair_next = 0;
  bit   prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      prev_stall = 1'b0;
    end else begin
      chk("tvalid", 64'(m_axis_tvalid), 64'(m_outv));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (m_outv) chk("tdata", 64'(m_axis_tdata), 64'(m_outd));
      if (prev_stall) chk("stall_stable", 64'(m_axis_tdata), 64'(prev_data));
      if (m_axis_tvalid && m_axis_tready) begin
        nbeats = nbeats + 1;
        seen_q.push_back(m_axis_tdata);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(m_axis_tdata), 64'hDEAD_0000_0000_0000);
        end else begin
          b = exp_q.pop_front();
          chk("beat_data", 64'(m_axis_tdata), 64'(b.d));
`ifdef GPIO_ARB_TUSER_EN
          chk("beat_tuser", 64'(m_axis_tuser), 64'(b.s));
`endif
        end
        if (fair_phase) begin
          chk("fair_order", 64'(m_axis_tdata[31:24]), 64'(fair_next));
          fair_next = (fair_next + 1) % N;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
    end
  end

  function automatic logic [N*DW-1:0] pack4(logic [31:0] d0, logic [31:0] d1,
                                            logic [31:0] d2, logic [31:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  // ---------------- stimulus -----------------------------------------------
  initial begin
    int b0;
    int cnt2;
    logic [N*DW-1:0] wd;
    rst_n         = 1'b0;
    src_wen       = '0;
    src_wdata     = '0;
    m_axis_tready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("reset_tdata", 64'(m_axis_tdata), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    #1 rst_n = 1'b1;

    // Simultaneous pushes right after reset: order 0x10..0x13, twice.
    for (int burst = 0; burst < 2; burst++) begin
      b0 = seen_q.size();
      step(4'hF, pack4(32'h10, 32'h11, 32'h12, 32'h13), 1'b1);
      idle(7, 1'b1);
      chk("burst_count", 64'(seen_q.size() - b0), 64'd4);
      for (int i = 0; i < 4; i++)
        if (seen_q.size() > b0 + i) chk("burst_order", 64'(seen_q[b0+i]), 64'(32'h10 + i));
    end

    // Single write from src2 with two-cycle latency.
    b0 = nbeats;
    step(4'b0100, pack4(0, 0, 32'hA5A5_0002, 0), 1'b1);
    chk("single_not_yet", 64'(m_axis_tvalid), 64'd0);
    step(4'b0000, '0, 1'b1);
    chk("single_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("single_tdata", 64'(m_axis_tdata), 64'hA5A5_0002);
    idle(4, 1'b1);
    chk("single_count", 64'(nbeats - b0), 64'd1);
    chk("single_ovf", 64'(overflow), 64'd0);

    // Backpressure: filler occupies output, src1 holds 0x1, then 0x2 is dropped.
    step(4'b0001, pack4(32'hF0, 0, 0, 0), 1'b0);
    step(4'b0000, '0, 1'b0);
    step(4'b0010, pack4(0, 32'h1, 0, 0), 1'b0);
    step(4'b0000, '0, 1'b0);
    step(4'b0010, pack4(0, 32'h2, 0, 0), 1'b0);
    idle(5, 1'b0);
    chk("bp_ovf1", 64'(overflow[1]), 64'd1);
    idle(6, 1'b1);
    cnt2 = 0;
    foreach (seen_q[i]) if (seen_q[i] == 32'h2) cnt2++;
    chk("bp_no_0x2", 64'(cnt2), 64'd0);
    chk("bp_last_0x1", 64'(seen_q[seen_q.size()-1]), 64'h1);

    // Level wen held high on src3 for 20 cycles.
    b0 = nbeats;
    for (int i = 0; i < 20; i++) step(4'b1000, pack4(0, 0, 0, 32'h33), 1'b1);
    idle(4, 1'b1);
    chk("level_count", 64'(nbeats - b0), 64'd1);
    chk("level_ovf3", 64'(overflow[3]), 64'd0);

    // Fairness: every source re-pushes, tready toggles 1/0.
    fair_next  = m_ptr;
    fair_phase = 1'b1;
    for (int c = 0; c < 40; c++) begin
      wd = '0;
      for (int i = 0; i < N; i++) wd[i*DW +: DW] = {8'(i), 24'(c)};
      step((c % 2 == 0) ? 4'hF : 4'h0, wd, (c % 2 == 0) ? 1'b1 : 1'b0);
    end
    idle(8, 1'b1);
    fair_phase = 1'b0;

    // Random traffic.
    for (int c = 0; c < 300; c++)
      step(4'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
    idle(8, 1'b1);

    // Reset mid-operation with output full and three holds pending.
    step(4'hF, pack4(32'hC0, 32'hC1, 32'hC2, 32'hC3), 1'b0);
    step(4'h0, '0, 1'b0);
    chk("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_ovf", 64'(overflow), 64'd0);
    src_wen   = 4'b0100;
    src_wdata = pack4(0, 0, 32'h0000_5A5A, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    b0 = nbeats;
    for (int i = 0; i < 5; i++) step(4'b0100, pack4(0, 0, 32'h0000_5A5A, 0), 1'b1);
    idle(4, 1'b1);
    chk("post_rst_one_push", 64'(nbeats - b0), 64'd1);

    for (int c = 0; c < 200; c++)
      step(4'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
    idle(12, 1'b1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
